// File: rtl/muldiv_hilo_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
//   md_op_t    : request opcode carried on req_op
//   md_state_t : top-level sequencer state, also exported on o_dbg_state
// State literals use an ST_ prefix because MD_DIV already names an opcode
// in this package scope.
package muldiv_pkg;

  localparam int MD_WIDTH      = 32;
  localparam int MD_MUL_CYCLES = 2;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  // MULT and DIV treat operands as two's complement; MULTU/DIVU do not.
  function automatic logic md_is_signed(md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_div_iter.sv
// Unsigned restoring radix-2 divider, one quotient bit per clock.
//   clk, resetn            : clock, async active-low reset
//   i_start                : load operands and begin (ignored while i_abort)
//   i_abort                : drop the division in progress
//   i_dividend, i_divisor  : unsigned operands, sampled on i_start
//   o_quotient, o_remainder: results, meaningful while o_valid
//   o_valid                : high for exactly one cycle after WIDTH iterations
// The divider frees itself on the edge after o_valid; the consumer must take
// the result on that edge.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;

  // The dividend shifts out of r_quo into the partial remainder MSB-first
  // while quotient bits shift in at the bottom of r_quo.
  always_comb begin
    w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    w_trial  = w_rem_sh - {1'b0, r_div};
    w_fits   = (w_rem_sh >= {1'b0, r_div});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_abort) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= CW'(WIDTH);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_rem <= w_fits ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_fits};
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_valid     = r_busy && (r_cnt == '0);
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/muldiv_hilo.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO pair.
//   clk, resetn        : clock, async active-low reset
//   req_valid, req_op  : request strobe and md_op_t opcode
//   req_a, req_b       : rs (dividend / MTHI/MTLO data) and rt (divisor)
//   req_ready          : unit idle; request taken this cycle if req_valid
//   flush              : abort in-flight op, no HI/LO commit
//   busy               : mul/div in flight (inverse of req_ready)
//   done               : one-cycle pulse while HI/LO first show a mul/div result
//   hi, lo             : architectural HI/LO registers
//   o_dbg_state        : current md_state_t
// Handshake: a request is taken on a rising edge where req_valid && req_ready
// && !flush; flush always wins, and the requester must hold the request
// stable until it is taken.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             req_ready,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       o_dbg_state
);

  localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES + 1) : 1;

  md_state_t          r_state;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic [MCW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_neg_q;
  logic               r_neg_r;

  md_op_t             w_op;
  logic               w_accept;
  logic               w_sext;
  logic [2*WIDTH-1:0] w_a_wide;
  logic [2*WIDTH-1:0] w_b_wide;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_div_start;
  logic               w_div_abort;
  logic [WIDTH-1:0]   w_div_quo;
  logic [WIDTH-1:0]   w_div_rem;
  logic               w_div_valid;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_op     = md_op_t'(req_op);
  assign w_accept = req_valid && req_ready && !flush;
  assign w_sext   = md_is_signed(w_op);

  // Extending both operands to the full product width makes the low 2*WIDTH
  // bits of a plain multiply exact for signed and unsigned operands alike.
  assign w_a_wide = {{WIDTH{w_sext & req_a[WIDTH-1]}}, req_a};
  assign w_b_wide = {{WIDTH{w_sext & req_b[WIDTH-1]}}, req_b};
  assign w_prod   = w_a_wide * w_b_wide;

  // The divider works on magnitudes. The quotient is negative when operand
  // signs differ; the remainder follows the dividend. MIN_INT is its own
  // magnitude as an unsigned value, so MIN_INT / -1 wraps to MIN_INT.
  assign w_a_neg = (w_op == MD_DIV) && req_a[WIDTH-1];
  assign w_b_neg = (w_op == MD_DIV) && req_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -req_a : req_a;
  assign w_b_mag = w_b_neg ? -req_b : req_b;

  // Divide by zero never starts the divider; it is answered from IDLE.
  assign w_div_start = w_accept && ((w_op == MD_DIV) || (w_op == MD_DIVU))
                       && (req_b != '0);
  assign w_div_abort = flush && (r_state == ST_DIV);

  div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk        (clk),
    .resetn     (resetn),
    .i_start    (w_div_start),
    .i_abort    (w_div_abort),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_quotient (w_div_quo),
    .o_remainder(w_div_rem),
    .o_valid    (w_div_valid)
  );

  // Sign fix-up is the extra cycle after the WIDTH iterations.
  assign w_quo_fix = r_neg_q ? -w_div_quo : w_div_quo;
  assign w_rem_fix = r_neg_r ? -w_div_rem : w_div_rem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_op)
              MD_MULT, MD_MULTU: begin
                r_prod  <= w_prod;
                r_cnt   <= MCW'(MUL_CYCLES - 1);
                r_state <= ST_MUL;
              end
              MD_DIV, MD_DIVU: begin
                if (req_b == '0) begin
                  r_done <= 1'b1;
                end else begin
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_state <= ST_DIV;
                end
              end
              MD_MTHI: r_hi <= req_a;
              MD_MTLO: r_lo <= req_a;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == '0) begin
            r_hi    <= r_prod[2*WIDTH-1:WIDTH];
            r_lo    <= r_prod[WIDTH-1:0];
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - MCW'(1);
          end
        end
        ST_DIV: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else if (w_div_valid) begin
            r_lo    <= w_quo_fix;
            r_hi    <= w_rem_fix;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign busy        = !req_ready;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule
